// File: rtl/pc_pkg.sv
// Shared types for the picoMIPS program counter.
// Holds the operation enum and the request priority decoder.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INCR,
    OP_BRANCH,
    OP_JUMP,
    OP_CALL,
    OP_RET
  } pc_op_t;

  // ret > call > jump > branch > incr > hold
  function automatic pc_op_t pc_decode(
    input logic ret,
    input logic call,
    input logic jump,
    input logic branch,
    input logic incr
  );
    pc_op_t op;
    op = OP_HOLD;
    if (ret)         op = OP_RET;
    else if (call)   op = OP_CALL;
    else if (jump)   op = OP_JUMP;
    else if (branch) op = OP_BRANCH;
    else if (incr)   op = OP_INCR;
    return op;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: register-array LIFO.
// Only the pointer is reset; entry contents are don't-care.
module pc_ras
  import pc_pkg::*;
#(
  parameter int Psize  = 6,
  parameter int Rdepth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Psize-1:0] din,
  output logic [Psize-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(Rdepth + 1);
  localparam int AW = (Rdepth > 1) ? $clog2(Rdepth) : 1;
  localparam logic [PW-1:0] PMAX = PW'(Rdepth);

  logic [Psize-1:0] mem [Rdepth];
  logic [PW-1:0]    ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign empty   = (ptr == '0);
  assign full    = (ptr == PMAX);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_idx  = AW'(ptr);
  assign rd_idx  = AW'(ptr - 1'b1);
  assign dout    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (do_pop)
      ptr <= ptr - 1'b1;
    else if (do_push)
      ptr <= ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push && !do_pop)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_stack.sv
// picoMIPS program counter with branch, jump and call/return.
// PCout is the registered PC feeding program memory.
module pc_stack
  import pc_pkg::*;
#(
  parameter int               Psize      = 6,
  parameter int               Rdepth     = 4,
  parameter logic [Psize-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCincr,
  input  logic             PCstall,
  input  logic             branch,
  input  logic [Psize-1:0] Boffset,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [Psize-1:0] Jaddr,
  output logic [Psize-1:0] PCout,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  pc_op_t           op;
  logic [Psize-1:0] pc;
  logic [Psize-1:0] pc_nxt;
  logic [Psize-1:0] pc_inc;
  logic [Psize-1:0] ras_top;
  logic             push;
  logic             pop;
  logic             err_set;

  // A stall masks every request, so nothing below sees it.
  assign op = PCstall ? OP_HOLD
                      : pc_decode(ret, call, jump, branch, PCincr);

  assign pc_inc = pc + 1'b1;

  always_comb begin
    pc_nxt  = pc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (op)
      OP_INCR:   pc_nxt = pc_inc;
      OP_BRANCH: pc_nxt = pc + Boffset;
      OP_JUMP:   pc_nxt = Jaddr;
      OP_CALL: begin
        if (ras_full) begin
          err_set = 1'b1;
        end else begin
          push   = 1'b1;
          pc_nxt = Jaddr;
        end
      end
      OP_RET: begin
        if (ras_empty) begin
          err_set = 1'b1;
        end else begin
          pop    = 1'b1;
          pc_nxt = ras_top;
        end
      end
      default: pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_ADDR;
      ras_err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (err_set)
        ras_err <= 1'b1;
    end
  end

  pc_ras #(
    .Psize  (Psize),
    .Rdepth (Rdepth)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign PCout = pc;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack (Psize=6, Rdepth=4, RESET_ADDR=0).
// Directed vectors push expectations; a monitor pops and compares.
module tb_pc_stack;

  typedef struct {
    string      tag;
    logic [5:0] pc;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       PCincr;
  logic       PCstall;
  logic       branch;
  logic [5:0] Boffset;
  logic       jump;
  logic       call;
  logic       ret;
  logic [5:0] Jaddr;
  logic [5:0] PCout;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_err;

  exp_t sb[$];
  int   n_vec;
  int   n_bad;

  pc_stack #(
    .Psize      (6),
    .Rdepth     (4),
    .RESET_ADDR (6'd0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PCincr    (PCincr),
    .PCstall   (PCstall),
    .branch    (branch),
    .Boffset   (Boffset),
    .jump      (jump),
    .call      (call),
    .ret       (ret),
    .Jaddr     (Jaddr),
    .PCout     (PCout),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one registered result per edge with a pending expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (PCout !== e.pc || ras_empty !== e.empty ||
          ras_full !== e.full || ras_err !== e.err) begin
        n_bad++;
        $display("FAIL %s: got pc=%0d e=%b f=%b err=%b, want pc=%0d e=%b f=%b err=%b",
                 e.tag, PCout, ras_empty, ras_full, ras_err,
                 e.pc, e.empty, e.full, e.err);
      end
    end
  end

  task automatic step(
    input string      tag,
    input logic       rst,
    input logic       inc,
    input logic       stl,
    input logic       br,
    input logic [5:0] boff,
    input logic       jmp,
    input logic       cl,
    input logic       rt,
    input logic [5:0] ja,
    input logic [5:0] epc,
    input logic       ee,
    input logic       ef,
    input logic       eerr
  );
    exp_t e;
    reset   = rst;
    PCincr  = inc;
    PCstall = stl;
    branch  = br;
    Boffset = boff;
    jump    = jmp;
    call    = cl;
    ret     = rt;
    Jaddr   = ja;
    e.tag   = tag;
    e.pc    = epc;
    e.empty = ee;
    e.full  = ef;
    e.err   = eerr;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  //                                 rst inc stl br boff  jmp cl rt ja     pc   e f err
  task automatic rst_(input string t);
    step(t, 1, 0, 0, 0, 6'd0, 0, 0, 0, 6'd0, 6'd0, 1, 0, 0);
  endtask

  task automatic inc_(input string t, input logic [5:0] p,
                      input logic ee, input logic ef, input logic er);
    step(t, 0, 1, 0, 0, 6'd0, 0, 0, 0, 6'd0, p, ee, ef, er);
  endtask

  task automatic jmp_(input string t, input logic [5:0] a,
                      input logic ee, input logic ef, input logic er);
    step(t, 0, 0, 0, 0, 6'd0, 1, 0, 0, a, a, ee, ef, er);
  endtask

  task automatic call_(input string t, input logic [5:0] a, input logic [5:0] p,
                       input logic ee, input logic ef, input logic er);
    step(t, 0, 0, 0, 0, 6'd0, 0, 1, 0, a, p, ee, ef, er);
  endtask

  task automatic ret_(input string t, input logic [5:0] p,
                      input logic ee, input logic ef, input logic er);
    step(t, 0, 0, 0, 0, 6'd0, 0, 0, 1, 6'd0, p, ee, ef, er);
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    PCincr  = 1'b0;
    PCstall = 1'b0;
    branch  = 1'b0;
    Boffset = '0;
    jump    = 1'b0;
    call    = 1'b0;
    ret     = 1'b0;
    Jaddr   = '0;

    // Reset and increment
    rst_("rst0");
    rst_("rst1");
    for (int i = 1; i <= 5; i++) inc_("incr", 6'(i), 1, 0, 0);
    step("rst_incr", 1, 1, 0, 0, 6'd0, 0, 0, 0, 6'd0, 6'd0, 1, 0, 0);

    // Wrap
    jmp_("jmp62", 6'd62, 1, 0, 0);
    inc_("inc63", 6'd63, 1, 0, 0);
    inc_("wrap0", 6'd0, 1, 0, 0);

    // Branch: base is current PC
    jmp_("jmp10", 6'd10, 1, 0, 0);
    step("br_m3", 0, 1, 0, 1, 6'b111101, 0, 0, 0, 6'd0, 6'd7, 1, 0, 0);
    jmp_("jmp60", 6'd60, 1, 0, 0);
    step("br_p5", 0, 0, 0, 1, 6'd5, 0, 0, 0, 6'd0, 6'd1, 1, 0, 0);

    // Call/return nesting
    jmp_("jmp5", 6'd5, 1, 0, 0);
    call_("call20", 6'd20, 6'd20, 0, 0, 0);
    inc_("inc21", 6'd21, 0, 0, 0);
    call_("call30", 6'd30, 6'd30, 0, 0, 0);
    ret_("ret22", 6'd22, 0, 0, 0);
    ret_("ret6", 6'd6, 1, 0, 0);

    // Overflow, sticky error, underflow after reset
    call_("c40", 6'd40, 6'd40, 0, 0, 0);
    call_("c41", 6'd41, 6'd41, 0, 0, 0);
    call_("c42", 6'd42, 6'd42, 0, 0, 0);
    call_("c43", 6'd43, 6'd43, 0, 1, 0);
    call_("ovf", 6'd40, 6'd43, 0, 1, 1);
    inc_("sticky", 6'd44, 0, 1, 1);
    ret_("ret43", 6'd43, 0, 0, 1);
    rst_("rst_mid");
    ret_("unf", 6'd0, 1, 0, 1);

    // Stall beats everything; ret beats call
    rst_("rst2");
    jmp_("jmp9", 6'd9, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 1, 1, 0, 6'd0, 0, 1, 0, 6'd20, 6'd9, 1, 0, 0);
    step("ret_call", 0, 0, 0, 0, 6'd0, 0, 1, 1, 6'd20, 6'd9, 1, 0, 1);
    inc_("no_push", 6'd10, 1, 0, 1);

    // Stall with a live RAS keeps the entry intact
    rst_("rst3");
    jmp_("jmp3", 6'd3, 1, 0, 0);
    call_("call50", 6'd50, 6'd50, 0, 0, 0);
    step("stall_ret", 0, 0, 1, 0, 6'd0, 0, 0, 1, 6'd0, 6'd50, 0, 0, 0);
    step("stall_ret", 0, 0, 1, 0, 6'd0, 0, 0, 1, 6'd0, 6'd50, 0, 0, 0);
    ret_("ret4", 6'd4, 1, 0, 0);
    step("jmp_br", 0, 1, 0, 1, 6'd7, 1, 0, 0, 6'd33, 6'd33, 1, 0, 0);

    PCincr = 1'b0;
    jump   = 1'b0;
    branch = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised next-generation program counter for the picoMIPS core.
- Replaces the increment-only counter with increment, PC-relative branch, absolute jump, and call/return through an internal return-address stack (RAS).
- Adds a pipeline stall input and RAS status/error flags.
- Sits between the decoder/control unit and program memory; PCout drives the program memory address.

Parameters:
- Psize, 6, PC/address width in bits.
- Rdepth, 4, RAS depth in entries; must be >= 1.
- RESET_ADDR, 0, PC value loaded on reset; Psize bits wide.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- PCincr  input  1  advance PC by 1.
- PCstall  input  1  freeze PC and RAS this cycle.
- branch  input  1  PC-relative branch.
- Boffset  input  Psize  signed two's-complement branch offset.
- jump  input  1  absolute jump to Jaddr.
- call  input  1  push return address, then jump to Jaddr.
- ret  input  1  pop the RAS into the PC.
- Jaddr  input  Psize  absolute target for jump and call.
- PCout  output  Psize  current PC (registered).
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds Rdepth entries.
- ras_err  output  1  sticky flag: RAS overflow or underflow occurred.

Behaviour:
- All outputs are registered or derived from registered state; a request sampled at edge N is visible on PCout after edge N.
- Reset values: PCout=RESET_ADDR, RAS pointer=0, ras_empty=1, ras_full=0, ras_err=0. RAS entry contents are don't-care.
- Reset takes effect at any time, including mid-call-sequence or while stalled; it discards all RAS entries.
- Priority, highest first: reset > PCstall > ret > call > jump > branch > PCincr > hold.
  - Only the winning operation takes effect.
  - Lower-priority requests asserted in the same cycle are ignored and do not set any flag.
- hold: PC unchanged.
- PCincr: PC <= PC+1 modulo 2^Psize. 2^Psize-1 wraps to 0.
- branch: PC <= PC + sign-extended Boffset, modulo 2^Psize.
  - The base is the current PC, not PC+1.
- jump: PC <= Jaddr. RAS untouched.
- call, RAS not full:
  - push (PC+1) mod 2^Psize;
  - PC <= Jaddr;
  - pointer +1.
- call, RAS full: no push; PC holds; ras_err <= 1.
- ret, RAS not empty:
  - PC <= top entry;
  - pointer -1.
- ret, RAS empty: PC holds; ras_err <= 1.
- call and ret in the same cycle: ret wins; call is dropped.
- ras_err is cleared only by reset.
- ras_empty is (pointer==0); ras_full is (pointer==Rdepth). Both update in the same cycle as the pointer.
- PCstall: PC, pointer, RAS contents and ras_err all unchanged, whatever the other inputs are.
- Pointer width is $clog2(Rdepth+1) bits. The pointer never exceeds Rdepth and never goes below 0.

Decomposition:
- Shared package pc_pkg:
  - enum pc_op_t {OP_HOLD, OP_INCR, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET};
  - priority-decode function that maps the request bits to pc_op_t.
- Sub-module pc_ras, parametrised by Psize and Rdepth:
  - register-array LIFO;
  - ports: push, pop, din, dout (top entry, combinational), empty, full;
  - synchronous reset of the pointer only.
- pc_stack holds the PC register, the next-PC mux, stall gating and the sticky error flag.

Test Plan (Psize=6, Rdepth=4, RESET_ADDR=0):
- Reset/increment:
  - Stimulus: reset=1 for 2 edges, then PCincr=1 for 5 edges; then reset=1 with PCincr=1.
  - Required: PCout 0,1,2,3,4,5; after the second reset, PCout=0 on the next edge and ras_empty=1.
- Wrap:
  - Stimulus: jump with Jaddr=62, then PCincr for 2 edges.
  - Required: PCout 62, 63, 0.
- Branch:
  - Stimulus: PC=10, branch with Boffset=6'b111101 (-3); then PC=60, Boffset=5.
  - Required: PCout=7; then PCout=1 (wrap).
- Call/return nesting:
  - Stimulus: PC=5, call Jaddr=20; PCincr; call Jaddr=30; ret; ret.
  - Required: PC 20, 21, 30 (RAS holds 6,22), 22, 6; ras_empty=1; ras_err=0.
- Overflow/underflow:
  - Stimulus: 4 successive calls, then a 5th call (Jaddr=40); then reset; then ret.
  - Required: after 4 calls, ras_full=1. The 5th call leaves PC unchanged and sets ras_err=1, which stays high until reset. After reset, the ret leaves PC=0 and sets ras_err=1.
- Stall and priority:
  - Stimulus: PC=9, PCstall=1 with call+PCincr asserted for 3 edges; then PCstall=0 with ret+call, RAS empty.
  - Required: during the stall, PC=9 and RAS unchanged. After the stall, ret wins: PC holds 9, ras_err=1, no push.
